contador_comparador_n: RTL

- Parametrised successor of the fixed 4-bit counter-plus-comparator datapath.
- Contains an N-bit modulo-M counter with synchronous clear, parallel load, count enable and up/down direction.
- Contains an unsigned magnitude comparator of the count against `chaves`.
- Adds a registered match sampler with a saturating hit counter.
- Sits in the experiment datapath under a control FSM, which drives `zera`/`carrega`/`conta`/`compara` and reads the flags.

---
 rtl/contador_comparador_n.sv | 69 ++++++
 1 files changed

// File: rtl/contador_comparador_n.sv
// N-bit modulo-M up/down counter with clear, load and enable, an unsigned
// comparator against chaves, and a registered match sampler with a saturating hit counter.
module contador_comparador_n #(
  parameter int N = 4,
  parameter int M = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         carrega,
  input  logic         conta,
  input  logic         decrementa,
  input  logic         compara,
  input  logic [N-1:0] chaves,
  output logic         menor,
  output logic         maior,
  output logic         igual,
  output logic         fim,
  output logic         acerto_reg,
  output logic [N-1:0] acertos,
  output logic [N-1:0] db_contagem
);

  localparam logic [N-1:0] LAST = N'(M - 1);
  localparam logic [N-1:0] ONE  = N'(1);
  // One extra bit so the load clamp works when M = 2^N.
  localparam logic [N:0]   MOD  = (N + 1)'(M);

  logic [N-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (zera) begin
      count <= '0;
    end else if (carrega) begin
      count <= ({1'b0, chaves} < MOD) ? chaves : LAST;
    end else if (conta) begin
      if (decrementa) begin
        count <= (count == '0) ? LAST : count - ONE;
      end else begin
        count <= (count == LAST) ? '0 : count + ONE;
      end
    end
  end

  assign menor       = count < chaves;
  assign maior       = count > chaves;
  assign igual       = count == chaves;
  assign fim         = decrementa ? (count == '0) : (count == LAST);
  assign db_contagem = count;

  // Samples igual as seen during this cycle, i.e. the pre-edge count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acerto_reg <= 1'b0;
      acertos    <= '0;
    end else if (zera) begin
      acerto_reg <= 1'b0;
      acertos    <= '0;
    end else if (compara) begin
      acerto_reg <= igual;
      if (igual && (acertos != '1)) begin
        acertos <= acertos + ONE;
      end
    end
  end

endmodule
